// File: rtl/sal_sched_pkg.sv
// Shared types for the DRAM command scheduler: command encoding and arbitration class indices.
package sal_sched_pkg;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        ACT = 3'd1,
        RD  = 3'd2,
        WR  = 3'd3,
        PRE = 3'd4,
        REF = 3'd5
    } cmd_t;

    // Lower index means higher priority.
    localparam logic [1:0] CLS_REF = 2'd0;
    localparam logic [1:0] CLS_PRE = 2'd1;
    localparam logic [1:0] CLS_COL = 2'd2;
    localparam logic [1:0] CLS_ACT = 2'd3;
    localparam int         NUM_CLS = 4;

endpackage

// File: rtl/sal_cmd_sched_if.sv
// Bank-controller side request/grant bundle plus the DRAM command bus of the scheduler.
// t_faw_i exists only when SAL_SCHED_TFAW_EN is defined.
interface sal_cmd_sched_if #(
    parameter int NUM_BANKS = 4,
    parameter int BA_WIDTH  = 2,
    parameter int RA_WIDTH  = 14,
    parameter int CA_WIDTH  = 10,
    parameter int TW        = 4
);
    import sal_sched_pkg::*;

    logic [NUM_BANKS-1:0]          act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i;
    logic [NUM_BANKS*RA_WIDTH-1:0] ra_i;
    logic [NUM_BANKS*CA_WIDTH-1:0] ca_i;
    logic [NUM_BANKS-1:0]          act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o;
    logic [TW-1:0]                 t_rrd_i, t_ccd_i, t_wtr_i, t_rtw_i;
`ifdef SAL_SCHED_TFAW_EN
    logic [TW+1:0]                 t_faw_i;
`endif
    logic                          cmd_valid_o;
    cmd_t                          cmd_o;
    logic [BA_WIDTH-1:0]           cmd_ba_o;
    logic [RA_WIDTH-1:0]           cmd_addr_o;

    modport master (
`ifdef SAL_SCHED_TFAW_EN
        output t_faw_i,
`endif
        output act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i, ra_i, ca_i,
        output t_rrd_i, t_ccd_i, t_wtr_i, t_rtw_i,
        input  act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o,
        input  cmd_valid_o, cmd_o, cmd_ba_o, cmd_addr_o
    );

    modport slave (
`ifdef SAL_SCHED_TFAW_EN
        input  t_faw_i,
`endif
        input  act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i, ra_i, ca_i,
        input  t_rrd_i, t_ccd_i, t_wtr_i, t_rtw_i,
        output act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o,
        output cmd_valid_o, cmd_o, cmd_ba_o, cmd_addr_o
    );

endinterface

// File: rtl/sal_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requesting bank at or after ptr.
module sal_rr_arbiter #(
    parameter int NUM_BANKS = 4
) (
    input  logic [NUM_BANKS-1:0]         req,
    input  logic [$clog2(NUM_BANKS)-1:0] ptr,
    output logic [NUM_BANKS-1:0]         gnt,
    output logic                         valid
);
    localparam int PW = $clog2(NUM_BANKS);

    logic [PW-1:0] idx;

    // NUM_BANKS is a power of two, so the index wraps for free.
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            idx = ptr + PW'(i);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sal_cmd_sched.sv
// Inter-bank DRAM command scheduler: class-priority + round-robin grant, timing counters, registered cmd bus.
// Define SAL_SCHED_TFAW_EN to add the four-activate window (t_faw_i).
module sal_cmd_sched
    import sal_sched_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int BA_WIDTH  = 2,
    parameter int RA_WIDTH  = 14,
    parameter int CA_WIDTH  = 10,
    parameter int TW        = 4
) (
    input logic            clk,
    input logic            rst_n,
    sal_cmd_sched_if.slave bus
);

    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
        return (v == '0) ? v : v - TW'(1);
    endfunction

    logic [TW-1:0]        rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt;
    logic [BA_WIDTH-1:0]  ptr [NUM_CLS];
    logic [NUM_BANKS-1:0] cls_req [NUM_CLS];
    logic [NUM_BANKS-1:0] cls_gnt [NUM_CLS];
    logic [NUM_CLS-1:0]   cls_vld;
    logic [NUM_BANKS-1:0] wr_only, win;
    logic                 rd_ok, wr_ok, act_ok, any_gnt, act_g, rd_g, wr_g;
    logic [1:0]           sel_cls;
    logic [BA_WIDTH-1:0]  win_ba;

    logic                 vld_p0, vld_p1;
    cmd_t                 cmd_p0, cmd_p1;
    logic [BA_WIDTH-1:0]  ba_p0, ba_p1;
    logic [RA_WIDTH-1:0]  addr_p0, addr_p1;

`ifdef SAL_SCHED_TFAW_EN
    function automatic logic [TW+1:0] dec_win(input logic [TW+1:0] v);
        return (v == '0) ? v : v - (TW+2)'(1);
    endfunction

    logic [TW+1:0] faw_win [4];
    logic          faw_free;
    logic [1:0]    faw_slot;

    // Any expired slot may take the new timestamp; lowest index is picked.
    always_comb begin
        faw_free = 1'b0;
        faw_slot = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (faw_win[i] == '0) begin
                faw_free = 1'b1;
                faw_slot = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) faw_win[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                faw_win[i] <= (act_g && faw_slot == 2'(i)) ? bus.t_faw_i : dec_win(faw_win[i]);
        end
    end

    assign act_ok = (rrd_cnt == '0) && faw_free;
`else
    assign act_ok = (rrd_cnt == '0);
`endif

    // Stage p0: eligibility, arbitration and next command, all combinational from requests.
    assign rd_ok   = (ccd_cnt == '0) && (wtr_cnt == '0);
    assign wr_ok   = (ccd_cnt == '0) && (rtw_cnt == '0);
    assign wr_only = bus.wr_req_i & ~bus.rd_req_i;

    assign cls_req[CLS_REF] = bus.ref_req_i;
    assign cls_req[CLS_PRE] = bus.pre_req_i;
    assign cls_req[CLS_COL] = (bus.rd_req_i & {NUM_BANKS{rd_ok}}) | (wr_only & {NUM_BANKS{wr_ok}});
    assign cls_req[CLS_ACT] = bus.act_req_i & {NUM_BANKS{act_ok}};

    for (genvar c = 0; c < NUM_CLS; c++) begin : g_arb
        sal_rr_arbiter #(.NUM_BANKS(NUM_BANKS)) u_arb (
            .req  (cls_req[c]),
            .ptr  (ptr[c]),
            .gnt  (cls_gnt[c]),
            .valid(cls_vld[c])
        );
    end

    always_comb begin
        any_gnt = 1'b0;
        sel_cls = CLS_REF;
        for (int c = NUM_CLS - 1; c >= 0; c--) begin
            if (cls_vld[c]) begin
                any_gnt = 1'b1;
                sel_cls = 2'(c);
            end
        end
        win    = any_gnt ? cls_gnt[sel_cls] : '0;
        win_ba = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            if (win[b]) win_ba = BA_WIDTH'(b);
    end

    assign act_g = any_gnt && (sel_cls == CLS_ACT);
    assign rd_g  = any_gnt && (sel_cls == CLS_COL) && (|(win & bus.rd_req_i));
    assign wr_g  = any_gnt && (sel_cls == CLS_COL) && !(|(win & bus.rd_req_i));

    assign bus.ref_gnt_o = (any_gnt && sel_cls == CLS_REF) ? win : '0;
    assign bus.pre_gnt_o = (any_gnt && sel_cls == CLS_PRE) ? win : '0;
    assign bus.rd_gnt_o  = rd_g  ? win : '0;
    assign bus.wr_gnt_o  = wr_g  ? win : '0;
    assign bus.act_gnt_o = act_g ? win : '0;

    always_comb begin
        vld_p0  = any_gnt;
        cmd_p0  = NOP;
        ba_p0   = win_ba;
        addr_p0 = '0;
        if (any_gnt) begin
            case (sel_cls)
                CLS_REF: cmd_p0 = REF;
                CLS_PRE: cmd_p0 = PRE;
                CLS_COL: begin
                    cmd_p0  = rd_g ? RD : WR;
                    addr_p0 = RA_WIDTH'(bus.ca_i[win_ba*CA_WIDTH +: CA_WIDTH]);
                end
                default: begin
                    cmd_p0  = ACT;
                    addr_p0 = bus.ra_i[win_ba*RA_WIDTH +: RA_WIDTH];
                end
            endcase
        end
    end

    // Stage p1: timing counters, round-robin pointers and the registered command bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrd_cnt <= '0;
            ccd_cnt <= '0;
            wtr_cnt <= '0;
            rtw_cnt <= '0;
            for (int c = 0; c < NUM_CLS; c++) ptr[c] <= '0;
            vld_p1  <= 1'b0;
            cmd_p1  <= NOP;
            ba_p1   <= '0;
            addr_p1 <= '0;
        end else begin
            rrd_cnt <= act_g          ? bus.t_rrd_i : dec_sat(rrd_cnt);
            ccd_cnt <= (rd_g || wr_g) ? bus.t_ccd_i : dec_sat(ccd_cnt);
            wtr_cnt <= wr_g           ? bus.t_wtr_i : dec_sat(wtr_cnt);
            rtw_cnt <= rd_g           ? bus.t_rtw_i : dec_sat(rtw_cnt);
            if (any_gnt) ptr[sel_cls] <= win_ba + BA_WIDTH'(1);
            vld_p1  <= vld_p0;
            cmd_p1  <= cmd_p0;
            ba_p1   <= ba_p0;
            addr_p1 <= addr_p0;
        end
    end

    assign bus.cmd_valid_o = vld_p1;
    assign bus.cmd_o       = cmd_p1;
    assign bus.cmd_ba_o    = ba_p1;
    assign bus.cmd_addr_o  = addr_p1;

endmodule

// File: tb/tb_sal_cmd_sched.sv
// Bench for sal_cmd_sched: directed scenarios plus random traffic against a deadline-based reference model.
module tb_sal_cmd_sched;
    import sal_sched_pkg::*;

    localparam int NB = 4, BAW = 2, RAW = 14, CAW = 10, TW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sal_cmd_sched_if #(.NUM_BANKS(NB), .BA_WIDTH(BAW), .RA_WIDTH(RAW), .CA_WIDTH(CAW), .TW(TW)) bus ();

    sal_cmd_sched #(.NUM_BANKS(NB), .BA_WIDTH(BAW), .RA_WIDTH(RAW), .CA_WIDTH(CAW), .TW(TW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [NB-1:0]     s_act, s_rd, s_wr, s_pre, s_ref;
    logic [NB*RAW-1:0] s_ra;
    logic [NB*CAW-1:0] s_ca;
    logic [TW-1:0]     s_rrd, s_ccd, s_wtr, s_rtw;
    assign bus.act_req_i = s_act;
    assign bus.rd_req_i  = s_rd;
    assign bus.wr_req_i  = s_wr;
    assign bus.pre_req_i = s_pre;
    assign bus.ref_req_i = s_ref;
    assign bus.ra_i      = s_ra;
    assign bus.ca_i      = s_ca;
    assign bus.t_rrd_i   = s_rrd;
    assign bus.t_ccd_i   = s_ccd;
    assign bus.t_wtr_i   = s_wtr;
    assign bus.t_rtw_i   = s_rtw;
`ifdef SAL_SCHED_TFAW_EN
    logic [TW+1:0] s_faw;
    assign bus.t_faw_i = s_faw;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each timing rule is a cycle number from which the dependent command is legal.
    int cyc;
    int act_rdy, col_rdy, rd_rdy, wr_rdy;
    int ptr_m [4];
    int faw_q [$];
    bit hold;
    logic           exp_vld;
    cmd_t           exp_cmd;
    logic [BAW-1:0] exp_ba;
    logic [RAW-1:0] exp_addr;

    logic           obs_vld;
    cmd_t           obs_cmd;
    logic [BAW-1:0] obs_ba;
    logic [RAW-1:0] obs_addr;
    logic [NB-1:0]  obs_act, obs_rd, obs_wr, obs_pre, obs_ref;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NB-1:0] req, input int p);
        for (int i = 0; i < NB; i++) begin
            int b;
            b = (p + i) % NB;
            if (req[b]) return b;
        end
        return -1;
    endfunction

    task automatic clear_reqs();
        s_act = '0; s_rd = '0; s_wr = '0; s_pre = '0; s_ref = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_reqs();
        act_rdy = 0; col_rdy = 0; rd_rdy = 0; wr_rdy = 0;
        for (int c = 0; c < 4; c++) ptr_m[c] = 0;
        faw_q.delete();
        exp_vld = 1'b0;
        exp_cmd = NOP;
        @(negedge clk);
        check_val("rst_valid", bus.cmd_valid_o, 0);
        check_val("rst_cmd", bus.cmd_o, NOP);
        check_val("rst_ba", bus.cmd_ba_o, 0);
        check_val("rst_addr", bus.cmd_addr_o, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock: check the registered bus and this cycle's grants, advance the model, retire granted requests.
    task automatic step();
        logic [NB-1:0] col_e, e_ref, e_pre, e_rd, e_wr, e_act;
        bit rd_ok, wr_ok, act_ok, is_rd;
        int cls, b;
        @(negedge clk);
        obs_vld = bus.cmd_valid_o; obs_cmd = bus.cmd_o; obs_ba = bus.cmd_ba_o; obs_addr = bus.cmd_addr_o;
        obs_act = bus.act_gnt_o; obs_rd = bus.rd_gnt_o; obs_wr = bus.wr_gnt_o;
        obs_pre = bus.pre_gnt_o; obs_ref = bus.ref_gnt_o;
        check_val("cmd_valid", obs_vld, exp_vld);
        check_val("cmd", obs_cmd, exp_cmd);
        if (exp_vld) begin
            check_val("cmd_ba", obs_ba, exp_ba);
            check_val("cmd_addr", obs_addr, exp_addr);
        end

        for (int i = faw_q.size() - 1; i >= 0; i--)
            if (faw_q[i] <= cyc) faw_q.delete(i);
        rd_ok  = (cyc >= col_rdy) && (cyc >= rd_rdy);
        wr_ok  = (cyc >= col_rdy) && (cyc >= wr_rdy);
        act_ok = (cyc >= act_rdy);
`ifdef SAL_SCHED_TFAW_EN
        if (faw_q.size() >= 4) act_ok = 1'b0;
`endif
        for (int i = 0; i < NB; i++) col_e[i] = s_rd[i] ? rd_ok : (s_wr[i] && wr_ok);

        cls = -1; b = -1; is_rd = 1'b0;
        if (|s_ref)                begin cls = 0; b = rr_pick(s_ref, ptr_m[0]); end
        else if (|s_pre)           begin cls = 1; b = rr_pick(s_pre, ptr_m[1]); end
        else if (|col_e)           begin cls = 2; b = rr_pick(col_e, ptr_m[2]); end
        else if (act_ok && |s_act) begin cls = 3; b = rr_pick(s_act, ptr_m[3]); end

        e_ref = '0; e_pre = '0; e_rd = '0; e_wr = '0; e_act = '0;
        exp_vld = 1'b0; exp_cmd = NOP; exp_ba = '0; exp_addr = '0;
        if (cls >= 0) begin
            ptr_m[cls] = (b + 1) % NB;
            exp_vld = 1'b1;
            exp_ba  = BAW'(b);
            case (cls)
                0: begin e_ref[b] = 1'b1; exp_cmd = REF; end
                1: begin e_pre[b] = 1'b1; exp_cmd = PRE; end
                2: begin
                    is_rd = s_rd[b];
                    exp_addr[CAW-1:0] = s_ca[b*CAW +: CAW];
                    col_rdy = cyc + int'(s_ccd) + 1;
                    if (is_rd) begin e_rd[b] = 1'b1; exp_cmd = RD; wr_rdy = cyc + int'(s_rtw) + 1; end
                    else       begin e_wr[b] = 1'b1; exp_cmd = WR; rd_rdy = cyc + int'(s_wtr) + 1; end
                end
                default: begin
                    e_act[b] = 1'b1; exp_cmd = ACT;
                    exp_addr = s_ra[b*RAW +: RAW];
                    act_rdy  = cyc + int'(s_rrd) + 1;
`ifdef SAL_SCHED_TFAW_EN
                    faw_q.push_back(cyc + int'(s_faw) + 1);
`endif
                end
            endcase
        end
        check_val("gnt_ref", obs_ref, e_ref);
        check_val("gnt_pre", obs_pre, e_pre);
        check_val("gnt_rd", obs_rd, e_rd);
        check_val("gnt_wr", obs_wr, e_wr);
        check_val("gnt_act", obs_act, e_act);

        @(posedge clk);
        #1;
        cyc++;
        if (cls >= 0 && !hold) begin
            case (cls)
                0: s_ref[b] = 1'b0;
                1: s_pre[b] = 1'b0;
                2: if (is_rd) s_rd[b] = 1'b0; else s_wr[b] = 1'b0;
                default: s_act[b] = 1'b0;
            endcase
        end
    endtask

    task automatic rand_reqs();
        for (int b = 0; b < NB; b++) begin
            s_ra[b*RAW +: RAW] = RAW'($urandom());
            s_ca[b*CAW +: CAW] = CAW'($urandom());
            if (!(s_act[b] | s_rd[b] | s_wr[b] | s_pre[b] | s_ref[b]) && $urandom_range(0, 9) < 3) begin
                case ($urandom_range(0, 9))
                    0:       s_ref[b] = 1'b1;
                    1, 2:    s_pre[b] = 1'b1;
                    3, 4:    s_act[b] = 1'b1;
                    5, 6:    s_rd[b]  = 1'b1;
                    7, 8:    s_wr[b]  = 1'b1;
                    default: begin s_rd[b] = 1'b1; s_wr[b] = 1'b1; end
                endcase
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        logic [NB-1:0] trrd_exp [5];
        logic [CAW-1:0] ca0;
        cyc = 0; hold = 1'b0;
        clear_reqs();
        s_rrd = '0; s_ccd = '0; s_wtr = '0; s_rtw = '0;
`ifdef SAL_SCHED_TFAW_EN
        s_faw = '0;
`endif
        for (int b = 0; b < NB; b++) begin
            s_ra[b*RAW +: RAW] = RAW'($urandom());
            s_ca[b*CAW +: CAW] = CAW'($urandom());
        end
        do_reset();

        // First read out of reset
        ca0 = s_ca[CAW-1:0];
        s_rd = 4'b0001;
        step();
        check_val("first_rd_gnt", obs_rd, 4'b0001);
        step();
        check_val("first_rd_valid", obs_vld, 1);
        check_val("first_rd_cmd", obs_cmd, RD);
        check_val("first_rd_ba", obs_ba, 0);
        check_val("first_rd_addr", obs_addr, 32'(ca0));

        // Class priority
        s_ref = 4'b0010; s_pre = 4'b0100; s_act = 4'b1000;
        step(); check_val("prio_ref", obs_ref, 4'b0010);
        step(); check_val("prio_pre", obs_pre, 4'b0100);
        step(); check_val("prio_act", obs_act, 4'b1000);

        // Round robin with held requests
        hold = 1'b1; s_act = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check_val("rr_act", obs_act, 32'(1 << (k % 4)));
        end
        hold = 1'b0; clear_reqs();
        step();

        // tRRD spacing; ACT pointer now sits at bank 1
        s_rrd = 4'd3;
        step();
        trrd_exp = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        s_act = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            step();
            check_val("trrd_act", obs_act, trrd_exp[k]);
        end
        step();

        // Write-to-read then read-to-write turnaround
        s_rrd = '0; s_wtr = 4'd2; s_rtw = 4'd1; s_ccd = '0;
        step();
        s_wr = 4'b0001;
        step(); check_val("wtr_wr0", obs_wr, 4'b0001);
        s_rd = 4'b0010;
        step(); check_val("wtr_wait1", obs_rd, 0);
        step(); check_val("wtr_wait2", obs_rd, 0);
        step(); check_val("wtr_rd", obs_rd, 4'b0010);
        s_wr = 4'b0001;
        step(); check_val("rtw_wait", obs_wr, 0);
        step(); check_val("rtw_wr", obs_wr, 4'b0001);
        step();

`ifdef SAL_SCHED_TFAW_EN
        // Four-activate window
        s_wtr = '0; s_rtw = '0; s_faw = 6'd10;
        step();
        hold = 1'b1; s_act = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            step();
            check_val("tfaw_act", 32'(|obs_act), 32'(k < 4 || k == 11));
        end
        hold = 1'b0; clear_reqs();
        step();
`endif

        // Random traffic, timing changed only while idle, one reset in the middle of traffic
        for (int blk = 0; blk < 6; blk++) begin
            clear_reqs();
            step();
            step();
            s_rrd = TW'($urandom_range(0, 4));
            s_ccd = TW'($urandom_range(0, 3));
            s_wtr = TW'($urandom_range(0, 4));
            s_rtw = TW'($urandom_range(0, 4));
`ifdef SAL_SCHED_TFAW_EN
            s_faw = (TW+2)'($urandom_range(4, 20));
`endif
            for (int i = 0; i < 250; i++) begin
                rand_reqs();
                step();
                if (blk == 3 && i == 120) do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
